// File: rtl/ft245_bus_pkg.sv
// Shared types and constants for the 68000 <-> FT245 FIFO bus-cycle sequencer.
package ft245_bus_pkg;

    // Bus-cycle sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_STROBE,
        WR_WAIT,
        WR_STROBE,
        WR_HOLD,
        ACK,
        ERR
    } state_e;

    // addr[19:15] value that selects the FIFO device window 0x78000-0x7FFFF.
    localparam logic [4:0] DEV_BASE = 5'b01111;

    // Register regions selected by addr[14:13].
    localparam logic [1:0] REG_RX   = 2'b00;
    localparam logic [1:0] REG_TX   = 2'b01;
    localparam logic [1:0] REG_STAT = 2'b10;
    localparam logic [1:0] REG_LED  = 2'b11;

    // True when the upper address byte (addr[19:12]) falls in the device window.
    function automatic logic dev_hit(input logic [7:0] a);
        return a[7:3] == DEV_BASE;
    endfunction

endpackage

// File: rtl/ft245_bus_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous FIFO flag inputs.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops; reset to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ft245_bus_ctrl.sv
// Bus-cycle sequencer between the 68000 and an FT245-style USB FIFO.
// Decodes the device window, times the FIFO strobes, waits on the FIFO
// flags with a timeout, and generates DTACK/BERR for the CPU.
module ft245_bus_ctrl
    import ft245_bus_pkg::*;
#(
    parameter int RD_PULSE = 3,
    parameter int WR_PULSE = 3,
    parameter int TIMEOUT  = 1023,
    parameter int CNT_W    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       _as,
    input  logic       _ds,
    input  logic       rw,
    input  logic       fc0,
    input  logic       fc1,
    input  logic [7:0] addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_doe,
    output logic       _dtack,
    output logic       _berr,
    input  logic       _rdf,
    input  logic       _txe,
    output logic       _rd,
    output logic       wr,
    input  logic [7:0] fifo_din,
    output logic [7:0] fifo_dout,
    output logic       fifo_oe,
    output logic       status_led
);

    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dtack_q;
    logic             berr_q;
    logic             rd_q;
    logic             wr_q;
    logic             fifo_oe_q;
    logic             cpu_doe_q;
    logic [7:0]       rd_data_q;
    logic [7:0]       fifo_dout_q;
    logic             led_q;

    logic             rdf_s;
    logic             txe_s;
    logic             start;
    logic [1:0]       region;
    logic [7:0]       ack_data;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rdf (
        .clk   (clk),
        .reset (reset),
        .d_i   (_rdf),
        .q_o   (rdf_s)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sync_txe (
        .clk   (clk),
        .reset (reset),
        .d_i   (_txe),
        .q_o   (txe_s)
    );

    // Decode the CPU access; interrupt-acknowledge cycles never hit the device.
    always_comb begin
        region   = addr[2:1];
        start    = ~_as & ~_ds & dev_hit(addr) & ~(fc0 & fc1);
        ack_data = 8'h00;
        if (rw && region == REG_STAT) begin
            ack_data = {7'b0, addr[0] ? txe_s : rdf_s};
        end
    end

    // Sequencer: every output is registered alongside the state transition.
    // rd_data_q doubles as the CPU read-back register for all read cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dtack_q     <= 1'b1;
            berr_q      <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b0;
            fifo_oe_q   <= 1'b0;
            cpu_doe_q   <= 1'b0;
            rd_data_q   <= 8'h00;
            fifo_dout_q <= 8'h00;
            led_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        if (rw && region == REG_RX) begin
                            state_q <= RD_WAIT;
                        end else if (!rw && region == REG_TX) begin
                            state_q     <= WR_WAIT;
                            fifo_dout_q <= cpu_din;
                        end else begin
                            // Status read, LED write, or wrong-direction access.
                            state_q   <= ACK;
                            dtack_q   <= 1'b0;
                            cpu_doe_q <= rw;
                            rd_data_q <= ack_data;
                            if (!rw && region == REG_LED) begin
                                led_q <= cpu_din[0];
                            end
                        end
                    end
                end

                RD_WAIT: begin
                    if (!rdf_s) begin
                        state_q <= RD_STROBE;
                        rd_q    <= 1'b0;
                        cnt_q   <= '0;
                    end else if (_as) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TMO_C) begin
                        state_q <= ERR;
                        berr_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RD_STROBE: begin
                    // The strobe always runs full length, even if _as rises.
                    if (cnt_q == RD_LAST) begin
                        state_q   <= ACK;
                        rd_q      <= 1'b1;
                        rd_data_q <= fifo_din;
                        dtack_q   <= 1'b0;
                        cpu_doe_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                WR_WAIT: begin
                    if (!txe_s) begin
                        state_q   <= WR_STROBE;
                        wr_q      <= 1'b1;
                        fifo_oe_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (_as) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TMO_C) begin
                        state_q <= ERR;
                        berr_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                WR_STROBE: begin
                    if (cnt_q == WR_LAST) begin
                        state_q <= WR_HOLD;
                        wr_q    <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                WR_HOLD: begin
                    // Data stays driven one cycle past the falling edge of wr.
                    state_q   <= ACK;
                    fifo_oe_q <= 1'b0;
                    dtack_q   <= 1'b0;
                    cnt_q     <= '0;
                end

                ACK: begin
                    if (_as) begin
                        state_q   <= IDLE;
                        dtack_q   <= 1'b1;
                        cpu_doe_q <= 1'b0;
                        rd_data_q <= 8'h00;
                        cnt_q     <= '0;
                    end
                end

                ERR: begin
                    if (_as) begin
                        state_q <= IDLE;
                        berr_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign _dtack     = dtack_q;
    assign _berr      = berr_q;
    assign _rd        = rd_q;
    assign wr         = wr_q;
    assign fifo_oe    = fifo_oe_q;
    assign fifo_dout  = fifo_dout_q;
    assign cpu_doe    = cpu_doe_q;
    assign cpu_dout   = rd_data_q;
    assign status_led = led_q;

endmodule

// File: doc/ft245_bus_ctrl.md
Name: ft245_bus_ctrl

Overview:
- Bus-cycle sequencer between the 68000 and the FT245-style USB FIFO in the device window 0x78000–0x7FFFF (addr[19:15] = 5'b01111).
- Decodes CPU accesses to serial-in, serial-out, status and LED registers.
- Times the FIFO _rd/wr strobes, waits on _rdf/_txe, and generates _dtack and _berr for the CPU.
- Replaces the free-running DTACK and ungated strobe glue in the board top level.

Parameters:
- RD_PULSE, 3, cycles _rd is held low (FIFO data valid by last cycle)
- WR_PULSE, 3, cycles wr is held high
- TIMEOUT, 1023, wait-state cycles before bus error
- CNT_W, 10, width of the shared cycle counter; must hold max(TIMEOUT, RD_PULSE, WR_PULSE)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- _as  in  1  CPU address strobe, active low
- _ds  in  1  CPU data strobe, active low
- rw  in  1  1 = read, 0 = write
- fc0, fc1  in  1 each  CPU function codes; fc0 & fc1 = interrupt acknowledge, never decoded as a device hit
- addr  in  8  CPU address bits [19:12]
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data
- cpu_doe  out  1  drive cpu_dout onto the CPU bus
- _dtack  out  1  data acknowledge, active low
- _berr  out  1  bus error, active low
- _rdf  in  1  FIFO receive data available, active low, asynchronous
- _txe  in  1  FIFO transmit space available, active low, asynchronous
- _rd  out  1  FIFO read strobe, active low
- wr  out  1  FIFO write strobe, active high; FIFO latches on the falling edge
- fifo_din  in  8  FIFO data bus in
- fifo_dout  out  8  FIFO data bus out
- fifo_oe  out  1  drive fifo_dout
- status_led  out  1  LED register bit 0

Behaviour:
- Reset values: state IDLE; _dtack=1, _berr=1, _rd=1, wr=0, fifo_oe=0, cpu_doe=0, cpu_dout=0, fifo_dout=0, status_led=0, counter=0, rd_data=0.
- _rdf and _txe pass through 2-flop synchronizers to rdf_s and txe_s. Both synchronizers reset to 1.
- Start condition, evaluated only in IDLE: ~_as & ~_ds & hit & ~(fc0&fc1), where hit = addr[19:15]==5'b01111.
- addr[14:13] selects the region:
  - 00 serial in (read)
  - 01 serial out (write)
  - 10 status: addr[12]=0 returns {7'b0, rdf_s}; addr[12]=1 returns {7'b0, txe_s}
  - 11 LED register (write)
- Wrong-direction access (write to 00 or 10, read from 01 or 11): go to ACK, cpu_dout=0, no FIFO strobe, no register change.

States and transitions:
- IDLE → RD_WAIT (00 read), WR_WAIT (01 write), ACK (status read or LED write).
- LED write: status_led <= cpu_din[0] in the start cycle.
- RD_WAIT: if rdf_s=0 → RD_STROBE. If _as=1 → IDLE (abort). If counter==TIMEOUT → ERR. Otherwise counter++.
- RD_STROBE: _rd=0 for RD_PULSE cycles. rd_data <= fifo_din on the last cycle. Then _rd=1 → ACK.
- WR_WAIT: same as RD_WAIT using txe_s → WR_STROBE. fifo_dout <= cpu_din on entry.
- WR_STROBE: fifo_oe=1, wr=1 for WR_PULSE cycles → WR_HOLD.
- WR_HOLD: wr=0, fifo_oe=1 for one cycle (data hold after falling edge) → ACK.
- ACK: _dtack=0. On reads, cpu_doe=1 with cpu_dout = rd_data or the status value. Stay until _as=1, then next cycle _dtack=1, cpu_doe=0, → IDLE.
- ERR: _berr=0 until _as=1, then → IDLE. No FIFO strobe has occurred.

Counter: cleared on every state change.

Latency, with start detected in cycle N:
- Status read / LED write: _dtack low at N+1.
- Read with rdf_s already 0: RD_WAIT N+1, _rd low N+2..N+1+RD_PULSE, _dtack low N+2+RD_PULSE.

Boundary conditions:
- _as rising during RD_STROBE/WR_STROBE/WR_HOLD: the strobe completes at full length (never truncated). ACK then exits after one cycle.
- _rdf/_txe changing mid-strobe: ignored.
- New start condition while in ACK: ignored until IDLE has been re-entered.
- reset mid-cycle: all outputs return to reset values in the next cycle, including an active strobe (_rd=1, wr=0).

Decomposition:
- Package ft245_bus_pkg:
  - state enum (IDLE, RD_WAIT, RD_STROBE, WR_WAIT, WR_STROBE, WR_HOLD, ACK, ERR)
  - DEV_BASE = 5'b01111
  - region codes REG_RX=2'b00, REG_TX=2'b01, REG_STAT=2'b10, REG_LED=2'b11
- Sub-module sync_2ff, instantiated twice (for _rdf and _txe); reset value given as a parameter.

Test Plan:
- Read 0x78000 with _rdf low, fifo_din=0xA5 → _rd low exactly 3 cycles; _dtack low at N+5; cpu_dout=0xA5 with cpu_doe=1 until _as rises.
- Write 0x7A000 with cpu_din=0x3C, _txe high for 20 cycles then low → no wr while waiting; then wr high 3 cycles with fifo_dout=0x3C; fifo_oe held 1 extra cycle; then _dtack low.
- Read 0x78000 with _rdf held high → _berr low at wait-state count 1023; _rd never asserted; _berr released after _as rises.
- Status reads 0x7C000 and 0x7D000 with _rdf=0, _txe=1 (after 3 sync cycles) → cpu_dout 0x00 then 0x01; _dtack low at N+1.
- Write 0x7E000 with cpu_din=0x01, then an interrupt-ack cycle (fc0=fc1=1) addressing 0x78000 → status_led=1; no _dtack or _rd for the ack cycle.
- Assert reset during RD_STROBE → next cycle _rd=1, _dtack=1, state IDLE.
